// File: rtl/rr_decode_arbiter.sv
// rr_decode_arbiter
// -----------------------------------------------------------------------------
// Four-requester round-robin arbiter for a shared resource that is selected
// through a 2-to-4 decoder. The registered owner index and grant-valid drive
// the decoder's I and En inputs directly. A matching one-hot grant goes back
// to the requesters.
//
// An owner keeps the grant until it drops its request. Re-arbitration only
// happens in IDLE, so there is always one idle bubble between two owners.
// The requester that received the most recent grant has the lowest priority
// in the next arbitration.
//
// Optional feature (compile-time macro GRANT_TIMEOUT_EN):
//   When defined, a hold counter limits one owner to TIMEOUT_CYC consecutive
//   grant cycles. A forced release pulses 'timeout' for one cycle.
//   When undefined, there is no counter, 'timeout' is always 0, and grants
//   are held indefinitely.
//
// Parameters:
//   TIMEOUT_CYC  maximum consecutive grant cycles per owner (2..255)
//   CNT_W        hold counter width, 2**CNT_W > TIMEOUT_CYC
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous, active-high reset
//   req      [3:0] request per requester, held for the whole resource use
//   gnt_idx  [1:0] encoded owner index (decoder I input)
//   gnt_vld  grant active (decoder En input)
//   gnt      [3:0] one-hot grant, zero when no grant is active
//   timeout  one-cycle pulse on forced release
// -----------------------------------------------------------------------------
module rr_decode_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld,
  output logic [3:0] gnt,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] last_idx_q, last_idx_d;
  logic [1:0] gnt_idx_q, gnt_idx_d;
  logic       gnt_vld_q, gnt_vld_d;
  logic [3:0] gnt_q, gnt_d;
  logic       timeout_q, timeout_d;

  logic [1:0] winner;
  logic       win_found;
  logic [1:0] cand;

`ifdef GRANT_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Reject parameter combinations that would let the hold counter wrap
  // before reaching its limit, or that make the limit meaningless.
  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255 || (64'd1 << CNT_W) <= 64'(TIMEOUT_CYC)) begin : g_param_check
    $error("rr_decode_arbiter: illegal TIMEOUT_CYC/CNT_W combination");
  end

  // Round-robin pick. Scan last_idx+1 .. last_idx+4 (mod 4). The 2-bit add
  // wraps naturally. The +4 step lands on last_idx itself, so the previous
  // owner is considered last.
  always_comb begin
    winner    = last_idx_q;
    win_found = 1'b0;
    cand      = 2'b00;
    for (int k = 1; k <= 4; k++) begin
      cand = last_idx_q + 2'(k);
      if (!win_found && req[cand]) begin
        winner    = cand;
        win_found = 1'b1;
      end
    end
  end

  // Next-state and next-output logic. Everything holds by default.
  // In IDLE, issue a grant to the winner.
  // In GRANT, release when the owner drops its request, or, when the
  // timeout feature is built in, when the owner has used up its hold budget.
  // gnt_idx and last_idx are left alone on release. The decoder index then
  // stays stable, and the evicted or releasing owner stays lowest priority.
  always_comb begin
    state_d    = state_q;
    last_idx_d = last_idx_q;
    gnt_idx_d  = gnt_idx_q;
    gnt_vld_d  = gnt_vld_q;
    gnt_d      = gnt_q;
    timeout_d  = 1'b0;
`ifdef GRANT_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d    = GRANT;
          last_idx_d = winner;
          gnt_idx_d  = winner;
          gnt_vld_d  = 1'b1;
          gnt_d      = 4'b0001 << winner;
`ifdef GRANT_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      GRANT: begin
        if (!req[gnt_idx_q]) begin
          state_d   = IDLE;
          gnt_vld_d = 1'b0;
          gnt_d     = 4'b0000;
`ifdef GRANT_TIMEOUT_EN
        end else if (cnt_q == HOLD_LAST) begin
          state_d   = IDLE;
          gnt_vld_d = 1'b0;
          gnt_d     = 4'b0000;
          timeout_d = 1'b1;
        end else begin
          cnt_d     = cnt_q + 1'b1;
`endif
        end
      end
      default: begin
        state_d   = IDLE;
        gnt_vld_d = 1'b0;
        gnt_d     = 4'b0000;
      end
    endcase
  end

  // State and output registers. last_idx resets to 3 so that requester 0
  // has first priority after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_idx_q <= 2'b11;
      gnt_idx_q  <= 2'b00;
      gnt_vld_q  <= 1'b0;
      gnt_q      <= 4'b0000;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_idx_q <= last_idx_d;
      gnt_idx_q  <= gnt_idx_d;
      gnt_vld_q  <= gnt_vld_d;
      gnt_q      <= gnt_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef GRANT_TIMEOUT_EN
  // The hold counter is cleared when a grant is issued and advances once
  // per grant cycle. It reaches TIMEOUT_CYC-1 in the owner's last allowed
  // cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign gnt_idx = gnt_idx_q;
  assign gnt_vld = gnt_vld_q;
  assign gnt     = gnt_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// tb_rr_decode_arbiter
// -----------------------------------------------------------------------------
// Scoreboard bench for rr_decode_arbiter. Each stimulus cycle runs a
// behavioural model of the arbiter. The model tracks the owner, the last
// winner and the cycles held, and pushes the expected outputs for the
// following edge into a queue. A separate monitor pops these entries on
// the falling edge and compares them with the DUT outputs.
// Build with +define+GRANT_TIMEOUT_EN to exercise the hold timeout
// (TIMEOUT_CYC=4).
// -----------------------------------------------------------------------------
module tb_rr_decode_arbiter;

  localparam int TIMEOUT = 4;
`ifdef GRANT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic [3:0] gnt;
  logic       timeout;

  rr_decode_arbiter #(
    .TIMEOUT_CYC(TIMEOUT),
    .CNT_W      (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .gnt_idx(gnt_idx),
    .gnt_vld(gnt_vld),
    .gnt    (gnt),
    .timeout(timeout)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [7:0] exp;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       sb_e;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;
  logic [1:0] glog[$];
  logic       prev_vld = 1'b0;

  // Reference model state: current owner (-1 when idle), last winner,
  // index shown on gnt_idx, and the number of grant cycles held so far.
  int m_owner, m_last, m_shown, m_held;

  // Count rising clock edges. The scoreboard uses this count to line
  // entries up with the edge that should produce them.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s @%0t: got to=%b vld=%b gnt=%b idx=%0d, expected to=%b vld=%b gnt=%b idx=%0d",
               name, $time, act[7], act[6], act[5:2], act[1:0], exp[7], exp[6], exp[5:2], exp[1:0]);
    end
  endfunction

  function automatic void modelReset();
    m_owner = -1;
    m_last  = 3;
    m_shown = 0;
    m_held  = 0;
  endfunction

  // One clock of the arbiter, written from the behavioural rules.
  // Returns {timeout, gnt_vld, gnt, gnt_idx} as they should appear after
  // the edge.
  function automatic logic [7:0] modelStep(input logic [3:0] r);
    logic       to;
    logic       vld;
    logic [3:0] oh;
    to = 1'b0;
    if (m_owner < 0) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_last + k) % 4;
        if (r[c]) begin
          m_owner = c;
          m_last  = c;
          m_shown = c;
          m_held  = 1;
          break;
        end
      end
    end else if (!r[m_owner]) begin
      m_owner = -1;
    end else if (TO_EN && m_held == TIMEOUT) begin
      m_owner = -1;
      to      = 1'b1;
    end else begin
      m_held++;
    end
    vld = (m_owner >= 0);
    oh  = vld ? 4'(1 << m_shown) : 4'b0000;
    return {to, vld, oh, 2'(m_shown)};
  endfunction

  // Drive one cycle of stimulus and queue the response expected after the
  // next rising edge. Called at posedge+1. Returns at the next posedge+1.
  task automatic applyStimulus(input logic [3:0] r);
    exp_t e;
    req   = r;
    e.exp = modelStep(r);
    e.due = cyc + 1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    req = 4'b0000;
    sb_q.delete();
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_values", {timeout, gnt_vld, gnt, gnt_idx}, 8'b0);
    rst = 1'b0;
  endtask

  // Monitor: on each falling edge, compare every due scoreboard entry.
  // It also logs the index at the start of each grant, so grant order can
  // be checked.
  always @(negedge clk) begin
    if (!rst) begin
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        sb_e = sb_q.pop_front();
        checkOutput("cycle_outputs", {timeout, gnt_vld, gnt, gnt_idx}, sb_e.exp);
      end
      if (gnt_vld && !prev_vld) glog.push_back(gnt_idx);
      prev_vld = gnt_vld;
    end else begin
      prev_vld = 1'b0;
    end
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] r;
    int         rot_exp[5];
    rot_exp = '{0, 1, 2, 3, 0};
    modelReset();

    // Single requester 2 held: granted after one cycle and held stable.
    doReset();
    repeat (8) applyStimulus(4'b0100);
    applyStimulus(4'b0000);
    applyStimulus(4'b0000);

    // All four request. Each owner drops its bit for one cycle after three
    // grant cycles.
    doReset();
    glog.delete();
    repeat (20) begin
      r = 4'b1111;
      if (m_owner >= 0 && m_held >= 3) r[m_owner] = 1'b0;
      applyStimulus(r);
    end
    checkOutput("rotation_count", {7'b0, glog.size() >= 5}, 8'd1);
    for (int i = 0; i < 5; i++) begin
      if (i < glog.size()) checkOutput("rotation_order", {6'b0, glog[i]}, {6'b0, 2'(rot_exp[i])});
    end

    // Owner 1 drops while requester 3 raises in the same cycle.
    doReset();
    repeat (3) applyStimulus(4'b0010);
    repeat (4) applyStimulus(4'b1000);
    applyStimulus(4'b0000);
    applyStimulus(4'b0000);

    // Asynchronous reset in the middle of a grant to requester 2.
    doReset();
    repeat (3) applyStimulus(4'b0100);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset", {timeout, gnt_vld, gnt, gnt_idx}, 8'b0);
    sb_q.delete();
    modelReset();
    req = 4'b1111;
    @(posedge clk);
    #1;
    rst = 1'b0;
    glog.delete();
    repeat (3) applyStimulus(4'b1111);
    checkOutput("restart_owner", {6'b0, (glog.size() > 0) ? glog[0] : 2'b11}, 8'd0);

    // Two requesters held. With the timeout enabled they alternate every
    // four grant cycles.
    doReset();
    repeat (14) applyStimulus(4'b0011);

    // The owner drops on exactly its fourth grant cycle: a normal release.
    doReset();
    repeat (8) begin
      r = (m_owner == 0 && m_held == TIMEOUT) ? 4'b0000 : 4'b0001;
      applyStimulus(r);
    end

    // Random requests. Each bit flips with probability 1/4 per cycle.
    doReset();
    r = 4'b0000;
    repeat (400) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(3) == 0) r[b] = ~r[b];
      end
      applyStimulus(r);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", {7'b0, sb_q.size() == 0}, 8'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
